// File: rtl/rv32ima_pkg.sv
// Shared types and defaults for the memory arbiter: FSM states, grant owner,
// access width, RAM status and the latched request record.
package rv32ima_pkg;

    localparam int STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    typedef enum logic [1:0] {
        MEM_WORD = 2'd0,
        MEM_HALF = 2'd1,
        MEM_BYTE = 2'd2
    } mem_width_t;

    typedef enum logic [1:0] {
        RAM_FREE  = 2'd0,
        RAM_BUSY  = 2'd1,
        RAM_DATA  = 2'd2,
        RAM_ERROR = 2'd3
    } ram_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] store;
        mem_width_t  width;
        logic        wen;
        grant_t      grant;
    } arb_req_t;

endpackage

// File: rtl/memory_arbiter_fsm_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the single-port RAM.
// slave = arbiter view, master = requester/RAM environment view.
interface memory_arbiter_fsm_if;
    import rv32ima_pkg::*;

    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        dmem_ren;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_store;
    mem_width_t  dmem_width;
    logic        ihit;
    logic        dhit;
    logic [31:0] imem_load;
    logic [31:0] dmem_load;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic        ram_ren;
    logic        ram_wen;
    mem_width_t  ram_width;
    logic [31:0] ram_load;
    ram_state_t  ram_state;

    modport slave (
        input  imem_ren, imem_addr, dmem_ren, dmem_wen, dmem_addr, dmem_store, dmem_width,
        input  ram_load, ram_state,
        output ihit, dhit, imem_load, dmem_load,
        output ram_addr, ram_store, ram_ren, ram_wen, ram_width
    );

    modport master (
        output imem_ren, imem_addr, dmem_ren, dmem_wen, dmem_addr, dmem_store, dmem_width,
        output ram_load, ram_state,
        input  ihit, dhit, imem_load, dmem_load,
        input  ram_addr, ram_store, ram_ren, ram_wen, ram_width
    );

endinterface

// File: rtl/arb_starve_counter.sv
// Counts consecutive data grants made while a fetch waits; requests a forced
// fetch grant once the count reaches STARVE_LIMIT (FETCH_STARVE_GUARD_EN builds only).
module arb_starve_counter
    import rv32ima_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic grant_valid,
    input  logic grant_data,
    input  logic imem_ren,
    output logic force_fetch
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] count_r;

    // Starvation count: bumps on data grants that bypass a pending fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (grant_valid) begin
            if (grant_data && imem_ren) begin
                count_r <= count_r + CW'(1);
            end else begin
                count_r <= '0;
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign force_fetch = imem_ren && (count_r == CW'(STARVE_LIMIT));

endmodule

// File: rtl/memory_arbiter_fsm.sv
// Arbitrates fetch and data requests onto one single-port RAM (IDLE/BUSY/RESP).
// Define FETCH_STARVE_GUARD_EN to bound how long data traffic can starve a fetch.
module memory_arbiter_fsm
    import rv32ima_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 nRST,
    memory_arbiter_fsm_if.slave  bus
);

    arb_state_t  state_r, state_next_s;
    arb_req_t    req_r, req_next_s;
    logic [31:0] resp_r, resp_next_s;
    logic        abort_r, abort_next_s;

    logic data_req_s;
    logic any_req_s;
    logic grant_data_s;
    logic grant_fire_s;
    logic force_fetch_s;
    logic grantee_live_s;
    logic ram_active_s;

    assign data_req_s     = bus.dmem_ren | bus.dmem_wen;
    assign any_req_s      = data_req_s | bus.imem_ren;
    assign grant_fire_s   = (state_r == IDLE) && any_req_s;
    assign grant_data_s   = data_req_s && !force_fetch_s;
    assign grantee_live_s = (req_r.grant == GRANT_D) ? data_req_s : bus.imem_ren;

`ifdef FETCH_STARVE_GUARD_EN
    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk         (CLK),
        .rst_n       (nRST),
        .grant_valid (grant_fire_s),
        .grant_data  (grant_data_s),
        .imem_ren    (bus.imem_ren),
        .force_fetch (force_fetch_s)
    );
`else
    assign force_fetch_s = (STARVE_LIMIT < 0);
`endif

    // Next-state, request latch and response capture
    always_comb begin
        state_next_s = state_r;
        req_next_s   = req_r;
        resp_next_s  = resp_r;
        abort_next_s = abort_r;
        case (state_r)
            IDLE: begin
                if (grant_fire_s) begin
                    req_next_s.grant = grant_data_s ? GRANT_D : GRANT_I;
                    req_next_s.addr  = grant_data_s ? bus.dmem_addr : bus.imem_addr;
                    req_next_s.store = grant_data_s ? bus.dmem_store : 32'h0000_0000;
                    req_next_s.width = grant_data_s ? bus.dmem_width : MEM_WORD;
                    req_next_s.wen   = grant_data_s & bus.dmem_wen;
                    abort_next_s     = 1'b0;
                    state_next_s     = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (bus.ram_state == RAM_DATA) begin
                    resp_next_s  = req_r.wen ? 32'h0000_0000 : bus.ram_load;
                    // A dropped request still finishes on the RAM but earns no hit
                    state_next_s = (abort_r || !grantee_live_s) ? IDLE : RESP;
                end else begin
                    abort_next_s = abort_r | ~grantee_live_s;
                end
            end
            RESP: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, request and response registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
            req_r   <= '0;
            resp_r  <= 32'h0000_0000;
            abort_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            req_r   <= req_next_s;
            resp_r  <= resp_next_s;
            abort_r <= abort_next_s;
        end
    end

    // Strobes drop in the RAM_DATA cycle itself so the RAM sees a single access
    assign ram_active_s  = (state_r == BUSY) && (bus.ram_state != RAM_DATA);
    assign bus.ram_ren   = ram_active_s && !req_r.wen;
    assign bus.ram_wen   = ram_active_s && req_r.wen;
    assign bus.ram_addr  = (state_r == BUSY) ? req_r.addr  : 32'h0000_0000;
    assign bus.ram_store = (state_r == BUSY) ? req_r.store : 32'h0000_0000;
    assign bus.ram_width = (state_r == BUSY) ? req_r.width : MEM_WORD;

    assign bus.ihit      = (state_r == RESP) && (req_r.grant == GRANT_I);
    assign bus.dhit      = (state_r == RESP) && (req_r.grant == GRANT_D);
    assign bus.imem_load = bus.ihit ? resp_r : 32'h0000_0000;
    assign bus.dmem_load = bus.dhit ? resp_r : 32'h0000_0000;

endmodule

// File: tb/tb_memory_arbiter_fsm.sv
// Directed bench for memory_arbiter_fsm: fetch, contention, load+store, abort,
// reset mid-access and starvation (result depends on FETCH_STARVE_GUARD_EN).
module tb_memory_arbiter_fsm;
    import rv32ima_pkg::*;

`ifdef FETCH_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic CLK;
    logic nRST;
    int   total;
    int   bad;
    int   ihit_seen;

    memory_arbiter_fsm_if bus ();

    memory_arbiter_fsm dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        ihit_seen = 0;
        nRST = 1'b0;
        bus.imem_ren = 1'b0;   bus.imem_addr = 32'h0;
        bus.dmem_ren = 1'b0;   bus.dmem_wen = 1'b0;
        bus.dmem_addr = 32'h0; bus.dmem_store = 32'h0;
        bus.dmem_width = MEM_WORD;
        bus.ram_load = 32'h0;  bus.ram_state = RAM_FREE;

        // Reset state
        #3;
        check("rst_ram_ren", {31'h0, bus.ram_ren}, 32'h0);
        check("rst_hits", {30'h0, bus.ihit, bus.dhit}, 32'h0);
        check("rst_ram_addr", bus.ram_addr, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;

        // Fetch-only
        @(negedge CLK);
        bus.imem_ren = 1'b1; bus.imem_addr = 32'h100;
        #1 check("idle_no_strobe", {31'h0, bus.ram_ren}, 32'h0);
        @(negedge CLK);
        check("fetch_ren_c1", {31'h0, bus.ram_ren}, 32'h1);
        check("fetch_addr", bus.ram_addr, 32'h100);
        @(negedge CLK);
        check("fetch_ren_c2", {31'h0, bus.ram_ren}, 32'h1);
        bus.ram_state = RAM_DATA; bus.ram_load = 32'h0000_0013;
        #1 check("fetch_ren_drop", {31'h0, bus.ram_ren}, 32'h0);
        @(negedge CLK);
        bus.ram_state = RAM_FREE;
        check("fetch_hits", {30'h0, bus.ihit, bus.dhit}, 32'h2);
        check("fetch_load", bus.imem_load, 32'h13);
        bus.imem_ren = 1'b0;
        @(negedge CLK);
        check("fetch_idle_hits", {30'h0, bus.ihit, bus.dhit}, 32'h0);
        check("fetch_idle_load", bus.imem_load, 32'h0);

        // Contention: store first, then fetch after one IDLE cycle
        bus.imem_ren = 1'b1; bus.imem_addr = 32'h300;
        bus.dmem_wen = 1'b1; bus.dmem_addr = 32'h200; bus.dmem_store = 32'hDEAD_BEEF;
        @(negedge CLK);
        check("cont_wen", {30'h0, bus.ram_wen, bus.ram_ren}, 32'h2);
        check("cont_store", bus.ram_store, 32'hDEAD_BEEF);
        bus.imem_addr = 32'h340;
        #1 check("cont_addr_stable", bus.ram_addr, 32'h200);
        bus.ram_state = RAM_DATA; bus.ram_load = 32'h0000_0055;
        #1 check("cont_wen_drop", {31'h0, bus.ram_wen}, 32'h0);
        @(negedge CLK);
        bus.ram_state = RAM_FREE;
        check("cont_dhit", {30'h0, bus.ihit, bus.dhit}, 32'h1);
        check("cont_store_load", bus.dmem_load, 32'h0);
        bus.dmem_wen = 1'b0;
        @(negedge CLK);
        check("cont_gap", {30'h0, bus.ram_ren, bus.ram_wen}, 32'h0);
        @(negedge CLK);
        check("cont_fetch_ren", {31'h0, bus.ram_ren}, 32'h1);
        check("cont_fetch_addr", bus.ram_addr, 32'h340);
        bus.ram_state = RAM_DATA; bus.ram_load = 32'h0000_0077;
        @(negedge CLK);
        bus.ram_state = RAM_FREE;
        check("cont_ihit", {30'h0, bus.ihit, bus.dhit}, 32'h2);
        check("cont_fetch_load", bus.imem_load, 32'h77);
        bus.imem_ren = 1'b0;
        @(negedge CLK);

        // Simultaneous load and store
        bus.dmem_ren = 1'b1; bus.dmem_wen = 1'b1;
        bus.dmem_addr = 32'h40; bus.dmem_store = 32'h1234; bus.dmem_width = MEM_HALF;
        @(negedge CLK);
        check("ls_strobes", {30'h0, bus.ram_wen, bus.ram_ren}, 32'h2);
        check("ls_width", {30'h0, bus.ram_width}, {30'h0, MEM_HALF});
        bus.ram_state = RAM_DATA; bus.ram_load = 32'h0000_AAAA;
        @(negedge CLK);
        bus.ram_state = RAM_FREE;
        check("ls_dhit", {30'h0, bus.ihit, bus.dhit}, 32'h1);
        check("ls_load_zero", bus.dmem_load, 32'h0);
        bus.dmem_ren = 1'b0; bus.dmem_wen = 1'b0; bus.dmem_width = MEM_WORD;
        @(negedge CLK);

        // Abort: fetch drops during BUSY
        bus.imem_ren = 1'b1; bus.imem_addr = 32'h500;
        @(negedge CLK);
        check("abort_ren", {31'h0, bus.ram_ren}, 32'h1);
        bus.imem_ren = 1'b0;
        @(negedge CLK);
        check("abort_ren_held", {31'h0, bus.ram_ren}, 32'h1);
        bus.ram_state = RAM_DATA; bus.ram_load = 32'h0000_0999;
        @(negedge CLK);
        bus.ram_state = RAM_FREE;
        check("abort_no_hit", {30'h0, bus.ihit, bus.dhit}, 32'h0);
        check("abort_no_load", bus.imem_load, 32'h0);
        bus.dmem_ren = 1'b1; bus.dmem_addr = 32'h580;
        @(negedge CLK);
        check("abort_then_idle", {31'h0, bus.ram_ren}, 32'h1);
        bus.ram_state = RAM_DATA; bus.ram_load = 32'h0000_0581;
        @(negedge CLK);
        bus.ram_state = RAM_FREE;
        check("abort_next_load", bus.dmem_load, 32'h581);
        bus.dmem_ren = 1'b0;
        @(negedge CLK);

        // Reset mid-BUSY
        bus.dmem_wen = 1'b1; bus.dmem_addr = 32'h600; bus.dmem_store = 32'hCAFE;
        @(negedge CLK);
        check("rb_wen", {31'h0, bus.ram_wen}, 32'h1);
        #1 nRST = 1'b0;
        #1;
        check("rb_wen_clr", {31'h0, bus.ram_wen}, 32'h0);
        check("rb_addr_clr", bus.ram_addr, 32'h0);
        check("rb_store_clr", bus.ram_store, 32'h0);
        check("rb_hits_clr", {30'h0, bus.ihit, bus.dhit}, 32'h0);
        bus.dmem_wen = 1'b0; bus.dmem_ren = 1'b1; bus.dmem_addr = 32'h640;
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        check("rb_regrant_ren", {30'h0, bus.ram_wen, bus.ram_ren}, 32'h1);
        check("rb_regrant_addr", bus.ram_addr, 32'h640);
        bus.ram_state = RAM_DATA; bus.ram_load = 32'h0000_BEEF;
        @(negedge CLK);
        bus.ram_state = RAM_FREE;
        check("rb_dhit", {30'h0, bus.ihit, bus.dhit}, 32'h1);
        check("rb_load", bus.dmem_load, 32'hBEEF);
        bus.dmem_ren = 1'b0;
        @(negedge CLK);

        // Starvation: both requests held, RAM answers in the first BUSY cycle
        bus.imem_ren = 1'b1; bus.imem_addr = 32'h700;
        bus.dmem_ren = 1'b1; bus.dmem_addr = 32'h800;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if ((i % 3) == 1) begin
                if (GUARD && (((i / 3) % 5) == 4))
                    check($sformatf("starve_hit%0d", i / 3), {30'h0, bus.ihit, bus.dhit}, 32'h2);
                else
                    check($sformatf("starve_hit%0d", i / 3), {30'h0, bus.ihit, bus.dhit}, 32'h1);
            end else begin
                check($sformatf("starve_gap%0d", i), {30'h0, bus.ihit, bus.dhit}, 32'h0);
            end
            if (bus.ihit) ihit_seen++;
            bus.ram_state = RAM_FREE;
            #1;
            if (bus.ram_ren || bus.ram_wen) bus.ram_state = RAM_DATA;
        end
        check("starve_ihit_total", ihit_seen, GUARD ? 32'd2 : 32'd0);
        bus.imem_ren = 1'b0; bus.dmem_ren = 1'b0; bus.ram_state = RAM_FREE;
        @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
